// File: rtl/aes_stream_pkg.sv
// Shared types and helpers for the AES streaming front-end.
package aes_stream_pkg;

  localparam int BLK_W = 128;

  typedef enum logic {
    MODE_ECB = 1'b0,
    MODE_CTR = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // Increment only the low ctr_w bits, wrapping inside that field; upper bits are never touched.
  function automatic logic [BLK_W-1:0] ctr_inc(input logic [BLK_W-1:0] ctr, input int ctr_w);
    logic [BLK_W-1:0] mask;
    if (ctr_w >= BLK_W) mask = '1;
    else mask = (BLK_W'(1) << ctr_w) - BLK_W'(1);
    return (ctr & ~mask) | ((ctr + BLK_W'(1)) & mask);
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous block FIFO; a pop frees its slot for a push in the same cycle, even when full.
module aes_blk_fifo #(
  parameter int DEPTH = 4,
  parameter int BLK_W = 128
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [BLK_W-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [BLK_W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [BLK_W-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (r_wr_ptr == r_rd_ptr);
  assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);
  assign head_o    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/aes_stream_ctrl.sv
// Streaming ECB/CTR sequencer in front of an iterative AES-128 core.
//
// state    | meaning
// ST_IDLE  | waiting for a buffered block; configuration accepted if FIFO empty
// ST_LOAD  | core_load_o high for one cycle, head block popped into r_pt
// ST_WAIT  | core busy; result captured in the cycle busy is low
// ST_OUT   | result held on dout_o until dout_ready_i
module aes_stream_ctrl
  import aes_stream_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CTR_W = 32
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             cfg_we_i,
  input  logic             cfg_mode_i,
  input  logic [BLK_W-1:0] cfg_key_i,
  input  logic [BLK_W-1:0] cfg_iv_i,
  input  logic             din_valid_i,
  output logic             din_ready_o,
  input  logic [BLK_W-1:0] din_i,
  output logic             dout_valid_o,
  input  logic             dout_ready_i,
  output logic [BLK_W-1:0] dout_o,
  output logic             core_load_o,
  output logic [BLK_W-1:0] core_key_o,
  output logic [BLK_W-1:0] core_data_o,
  input  logic             core_busy_i,
  input  logic [BLK_W-1:0] core_data_i,
  output logic [15:0]      blk_cnt_o,
  output logic             idle_o
);

  state_e           r_state;
  state_e           w_state_nxt;
  mode_e            r_mode;
  logic [BLK_W-1:0] r_key;
  logic [BLK_W-1:0] r_ctr;
  logic [BLK_W-1:0] r_pt;
  logic [BLK_W-1:0] r_dout;
  logic [BLK_W-1:0] r_core_data;
  logic             r_dout_valid;
  logic [15:0]      r_blk_cnt;

  logic             w_push;
  logic             w_pop;
  logic             w_start;
  logic             w_capture;
  logic             w_release;
  logic             w_cfg_ok;
  logic             w_full;
  logic             w_empty;
  logic [BLK_W-1:0] w_head;
  logic [BLK_W-1:0] w_result;

  aes_blk_fifo #(
    .DEPTH (DEPTH),
    .BLK_W (BLK_W)
  ) u_fifo (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (din_i),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  assign din_ready_o  = ~w_full;
  assign w_push       = din_valid_i & ~w_full;
  assign idle_o       = (r_state == ST_IDLE) & w_empty;
  assign w_cfg_ok     = cfg_we_i & idle_o;
  assign w_result     = (r_mode == MODE_CTR) ? (core_data_i ^ r_pt) : core_data_i;

  assign core_load_o  = (r_state == ST_LOAD);
  assign core_key_o   = r_key;
  assign core_data_o  = r_core_data;
  assign dout_o       = r_dout;
  assign dout_valid_o = r_dout_valid;
  assign blk_cnt_o    = r_blk_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode and single-cycle datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_start     = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_pop       = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!core_busy_i) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        if (dout_ready_i) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Configuration, core-facing block register, result capture and block counting.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_key        <= '0;
      r_mode       <= MODE_ECB;
      r_ctr        <= '0;
      r_pt         <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_core_data  <= '0;
      r_blk_cnt    <= '0;
    end else begin
      if (w_cfg_ok) begin
        r_key  <= cfg_key_i;
        r_mode <= mode_e'(cfg_mode_i);
        r_ctr  <= cfg_iv_i;
      end
      // Register the core operand on entry to LOAD so it is valid alongside the load pulse.
      if (w_start) r_core_data <= (r_mode == MODE_CTR) ? r_ctr : w_head;
      if (w_pop)   r_pt <= w_head;
      if (w_capture) begin
        r_dout       <= w_result;
        r_dout_valid <= 1'b1;
        r_blk_cnt    <= r_blk_cnt + 16'd1;
        if (r_mode == MODE_CTR) r_ctr <= ctr_inc(r_ctr, CTR_W);
      end else if (w_release) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl. The AES core is replaced by a behavioural stand-in
// with a programmable busy latency and a cheap keyed permutation, since the controller
// never inspects the cipher itself.
module tb_aes_stream_ctrl;

  localparam logic [127:0] MC  = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] JUNK = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
  localparam logic [127:0] K1  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] K2  = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] K3  = 128'h55555555_55555555_55555555_55555555;
  localparam logic [127:0] IVW = {96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'hFFFF_FFFF};
  localparam logic [127:0] IVW1 = {96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'h0000_0000};

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         cfg_we_i, cfg_mode_i;
  logic [127:0] cfg_key_i, cfg_iv_i;
  logic         din_valid_i, din_ready_o;
  logic [127:0] din_i;
  logic         dout_valid_o, dout_ready_i;
  logic [127:0] dout_o;
  logic         core_load_o;
  logic [127:0] core_key_o, core_data_o;
  logic         core_busy_i;
  logic [127:0] core_data_i;
  logic [15:0]  blk_cnt_o;
  logic         idle_o;

  aes_stream_ctrl #(.DEPTH(4), .CTR_W(32)) dut (
    .clk(clk), .rst_ni(rst_ni),
    .cfg_we_i(cfg_we_i), .cfg_mode_i(cfg_mode_i), .cfg_key_i(cfg_key_i), .cfg_iv_i(cfg_iv_i),
    .din_valid_i(din_valid_i), .din_ready_o(din_ready_o), .din_i(din_i),
    .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i), .dout_o(dout_o),
    .core_load_o(core_load_o), .core_key_o(core_key_o), .core_data_o(core_data_o),
    .core_busy_i(core_busy_i), .core_data_i(core_data_i),
    .blk_cnt_o(blk_cnt_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mock_enc(input logic [127:0] k, input logic [127:0] d);
    return {d[63:0], d[127:64]} ^ k ^ MC;
  endfunction

  // Core stand-in: busy from the cycle after load for lat cycles, junk on the data bus until done.
  int           lat = 3;
  int           m_cnt;
  logic [127:0] m_key, m_data;
  always @(posedge clk) begin
    if (!rst_ni) begin
      core_busy_i <= 1'b0;
      m_cnt       <= 0;
    end else if (core_load_o) begin
      core_busy_i <= 1'b1;
      m_cnt       <= lat;
      core_data_i <= JUNK;
      m_key       <= core_key_o;
      m_data      <= core_data_o;
    end else if (core_busy_i) begin
      if (m_cnt <= 1) begin
        core_busy_i <= 1'b0;
        core_data_i <= mock_enc(m_key, m_data);
      end
      m_cnt <= m_cnt - 1;
    end
  end

  logic [127:0] load_log[$];
  always @(posedge clk) begin
    if (rst_ni && core_load_o) load_log.push_back(core_data_o);
  end

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
    logic [127:0] core;
  } vec_t;
  vec_t vec [13];

  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic chk_reset(input string p);
    chki({p, "_dout_valid"}, int'(dout_valid_o), 0);
    chk ({p, "_dout"}, dout_o, '0);
    chki({p, "_core_load"}, int'(core_load_o), 0);
    chk ({p, "_core_data"}, core_data_o, '0);
    chk ({p, "_core_key"}, core_key_o, '0);
    chki({p, "_blk_cnt"}, int'(blk_cnt_o), 0);
    chki({p, "_idle"}, int'(idle_o), 1);
    chki({p, "_din_ready"}, int'(din_ready_o), 1);
  endtask

  task automatic do_cfg(input logic mode, input logic [127:0] key, input logic [127:0] iv);
    int t = 0;
    while (!idle_o && t < 200) begin @(negedge clk); t++; end
    if (!idle_o) timeout("cfg_idle");
    cfg_we_i = 1'b1; cfg_mode_i = mode; cfg_key_i = key; cfg_iv_i = iv;
    @(negedge clk);
    cfg_we_i = 1'b0;
  endtask

  task automatic push(input logic [127:0] d);
    int t = 0;
    while (!din_ready_o && t < 200) begin @(negedge clk); t++; end
    if (!din_ready_o) timeout("push_ready");
    din_valid_i = 1'b1; din_i = d;
    @(negedge clk);
    din_valid_i = 1'b0;
  endtask

  task automatic collect(input int idx);
    int t = 0;
    while (!dout_valid_o && t < 300) begin @(negedge clk); t++; end
    if (!dout_valid_o) timeout($sformatf("collect_%0d", idx));
    else begin
      exp_cnt++;
      chk($sformatf("dout_%0d", idx), dout_o, vec[idx].exp);
      chki($sformatf("blk_cnt_%0d", idx), int'(blk_cnt_o), exp_cnt);
    end
    @(negedge clk);
  endtask

  task automatic wait_loads(input int n);
    int t = 0;
    while (load_log.size() < n && t < 200) begin @(negedge clk); t++; end
    if (load_log.size() < n) timeout("wait_loads");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d0;
    int           l0;
    logic         ok_stable, ok_noload, ok_rdy, ok_quiet;

    rst_ni = 1'b0; cfg_we_i = 1'b0; cfg_mode_i = 1'b0; cfg_key_i = '0; cfg_iv_i = '0;
    din_valid_i = 1'b0; din_i = '0; dout_ready_i = 1'b1;

    vec[0]  = '{din: '0, exp: MC, core: '0};
    vec[1]  = '{din: {128{1'b1}}, exp: '0, core: '0};
    vec[2]  = '{din: '0, exp: '0, core: '0};
    vec[3]  = '{din: {16{8'hF0}}, exp: '0, core: '0};
    vec[4]  = '{din: {64'hFFFFFFFF_FFFFFFFF, 64'h0}, exp: '0, core: '0};
    vec[5]  = '{din: 128'h00112233445566778899AABBCCDDEEFF, exp: '0, core: '0};
    for (int i = 1; i <= 5; i++) begin
      vec[i].exp  = mock_enc(K1, vec[i].din);
      vec[i].core = vec[i].din;
    end
    vec[6]  = '{din: '0, exp: MC, core: '0};
    vec[7]  = '{din: '0, exp: 128'h0123456789ABCDEE_FEDCBA9876543210, core: 128'h1};
    vec[8]  = '{din: 128'hDEADBEEF_00000000_12345678_9ABCDEF0, exp: '0, core: IVW};
    vec[9]  = '{din: 128'h0F0F0F0F_11111111_22222222_33333333, exp: '0, core: IVW1};
    vec[8].exp = mock_enc(K2, IVW) ^ vec[8].din;
    vec[9].exp = mock_enc(K2, IVW1) ^ vec[9].din;
    vec[10] = '{din: 128'hCAFEF00D_CAFEF00D_01020304_05060708, exp: '0, core: '0};
    vec[10].exp  = mock_enc(K1, vec[10].din);
    vec[10].core = vec[10].din;
    vec[11] = vec[10];
    vec[12] = '{din: 128'h13579BDF_2468ACE0_13579BDF_2468ACE0, exp: '0, core: '0};
    vec[12].exp  = mock_enc('0, vec[12].din);
    vec[12].core = vec[12].din;

    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_ni = 1'b1;
    @(negedge clk);

    // Single ECB block with key 0.
    do_cfg(1'b0, '0, '0);
    push(vec[0].din);
    collect(0);
    chki("s1_loads", load_log.size(), 1);

    // Back-to-back ECB blocks against a stalled output: core holds one, FIFO fills with four.
    do_cfg(1'b0, K1, '0);
    dout_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) push(vec[i].din);
    chki("s2_ready_when_full", int'(din_ready_o), 0);
    begin
      int t = 0;
      while (!dout_valid_o && t < 300) begin @(negedge clk); t++; end
      if (!dout_valid_o) timeout("s2_first_valid");
    end
    d0 = dout_o;
    l0 = load_log.size();
    ok_stable = 1'b1; ok_noload = 1'b1; ok_rdy = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (dout_o !== d0 || !dout_valid_o) ok_stable = 1'b0;
      if (load_log.size() != l0) ok_noload = 1'b0;
      if (din_ready_o) ok_rdy = 1'b0;
    end
    chki("s2_loads_before_stall", l0, 2);
    chk ("s2_held_dout", d0, vec[1].exp);
    chki("s2_dout_stable", int'(ok_stable), 1);
    chki("s2_no_extra_load", int'(ok_noload), 1);
    chki("s2_ready_held_low", int'(ok_rdy), 1);
    dout_ready_i = 1'b1;
    for (int i = 1; i <= 5; i++) collect(i);

    // CTR from a zero IV, then a run that wraps the 32-bit counter field.
    do_cfg(1'b1, '0, '0);
    push(vec[6].din);
    push(vec[7].din);
    collect(6);
    collect(7);
    do_cfg(1'b1, K2, IVW);
    push(vec[8].din);
    push(vec[9].din);
    collect(8);
    collect(9);

    // Configuration write while the core is busy must be ignored entirely.
    do_cfg(1'b0, K1, '0);
    lat = 8;
    push(vec[10].din);
    wait_loads(11);
    repeat (3) @(negedge clk);
    chki("s5_busy_not_idle", int'(idle_o), 0);
    cfg_we_i = 1'b1; cfg_mode_i = 1'b1; cfg_key_i = K3; cfg_iv_i = 128'h123;
    @(negedge clk);
    cfg_we_i = 1'b0;
    chk("s5_key_kept", core_key_o, K1);
    collect(10);
    push(vec[11].din);
    collect(11);
    for (int i = 0; i < 12; i++) begin
      if (i < load_log.size()) chk($sformatf("core_data_%0d", i), load_log[i], vec[i].core);
      else timeout($sformatf("core_data_%0d_missing", i));
    end

    // Reset in the middle of WAIT with a block still buffered.
    lat = 20;
    push(vec[12].din);
    push(vec[12].din ^ 128'h1);
    wait_loads(13);
    repeat (4) @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    exp_cnt = 0;
    chk_reset("s6");
    rst_ni = 1'b1;
    l0 = load_log.size();
    ok_quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (dout_valid_o || load_log.size() != l0) ok_quiet = 1'b0;
    end
    chki("s6_fifo_flushed", int'(ok_quiet), 1);

    // After reset the mode is ECB and the key is zero.
    lat = 3;
    push(vec[12].din);
    collect(12);
    chk("s6_core_data", load_log[load_log.size()-1], vec[12].core);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
